// File: rtl/sma_pkg.sv
// Shared types and sizing helpers for the simple-moving-average filter.
package sma_pkg;

  typedef enum logic {
    RND_TRUNC   = 1'b0,
    RND_HALF_UP = 1'b1
  } rnd_mode_e;

  function automatic int sum_w(input int data_w, input int log2_depth);
    return data_w + log2_depth;
  endfunction

  function automatic int depth(input int log2_depth);
    return 1 << log2_depth;
  endfunction

endpackage

// File: rtl/sma_window_buf.sv
// Circular sample window: stores the last N accepted samples and exposes the
// entry that the next write will evict.
module sma_window_buf
  import sma_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int LOG2_DEPTH = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] oldest
);

  localparam int N = depth(LOG2_DEPTH);

  logic [DATA_W-1:0]     mem [N];
  logic [LOG2_DEPTH-1:0] wr_ptr;

  // The slot about to be overwritten is the oldest sample in the window.
  assign oldest = mem[wr_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) mem[i] <= '0;
      wr_ptr <= '0;
    end else if (clear) begin
      for (int i = 0; i < N; i++) mem[i] <= '0;
      wr_ptr <= '0;
    end else if (wr_en) begin
      mem[wr_ptr] <= wr_data;
      wr_ptr      <= wr_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/sma_filter.sv
// Moving average over the last 2^LOG2_DEPTH accepted samples, with optional
// half-up rounding, synchronous clear and warm-up suppression.
module sma_filter
  import sma_pkg::*;
#(
  parameter int DATA_W          = 8,
  parameter int LOG2_DEPTH      = 3,
  parameter int ROUND           = 0,
  parameter bit SUPPRESS_WARMUP = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_avg,
  output logic                  out_primed,
  output logic [LOG2_DEPTH:0]   fill_count
);

  localparam int SW   = sum_w(DATA_W, LOG2_DEPTH);
  localparam int N    = depth(LOG2_DEPTH);
  localparam int FC_W = LOG2_DEPTH + 1;

  localparam logic [FC_W-1:0] FULL = FC_W'(N);
  localparam logic [SW-1:0]   HALF = (ROUND == int'(RND_HALF_UP)) ? SW'(N / 2) : '0;

  logic              accept;
  logic [DATA_W-1:0] oldest;
  logic [SW-1:0]     sum_q;
  logic [SW-1:0]     sum_next;
  logic [SW-1:0]     sum_rnd;
  logic [FC_W-1:0]   fill_next;
  logic              full_next;

  assign accept = in_valid & ~clear;

  // Empty slots hold zero, so subtracting the evicted entry is always exact.
  assign sum_next  = sum_q - SW'(oldest) + SW'(in_data);
  assign sum_rnd   = sum_next + HALF;
  assign fill_next = (fill_count == FULL) ? fill_count : fill_count + 1'b1;
  assign full_next = (fill_next == FULL);

  sma_window_buf #(
    .DATA_W    (DATA_W),
    .LOG2_DEPTH(LOG2_DEPTH)
  ) u_window (
    .clk    (clk),
    .reset  (reset),
    .clear  (clear),
    .wr_en  (accept),
    .wr_data(in_data),
    .oldest (oldest)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_q      <= '0;
      fill_count <= '0;
      out_primed <= 1'b0;
      out_valid  <= 1'b0;
      out_avg    <= '0;
    end else if (clear) begin
      sum_q      <= '0;
      fill_count <= '0;
      out_primed <= 1'b0;
      out_valid  <= 1'b0;
      out_avg    <= '0;
    end else if (accept) begin
      sum_q      <= sum_next;
      fill_count <= fill_next;
      out_primed <= full_next;
      // With warm-up suppression the average is only published once full.
      if (!SUPPRESS_WARMUP || full_next) begin
        out_valid <= 1'b1;
        out_avg   <= DATA_W'(sum_rnd >> LOG2_DEPTH);
      end else begin
        out_valid <= 1'b0;
      end
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sma_filter.sv
// Self-checking bench for sma_filter: truncating, rounding and warm-up
// suppressing instances share one stimulus stream and one window model.
module tb_sma_filter;

  localparam int DW = 8;
  localparam int L  = 3;
  localparam int N  = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;

  logic          ov_t, ov_r, ov_s;
  logic [DW-1:0] avg_t, avg_r, avg_s;
  logic          op_t, op_r, op_s;
  logic [L:0]    fc_t, fc_r, fc_s;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the window is simply the last N accepted samples.
  int win[$];
  int m_avg_t, m_avg_r, m_avg_s;
  int m_valid_t, m_valid_s, m_fill, m_primed;

  always #5 clk = ~clk;

  sma_filter #(.DATA_W(DW), .LOG2_DEPTH(L), .ROUND(0), .SUPPRESS_WARMUP(1'b0)) dut_t (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov_t), .out_avg(avg_t), .out_primed(op_t), .fill_count(fc_t));

  sma_filter #(.DATA_W(DW), .LOG2_DEPTH(L), .ROUND(1), .SUPPRESS_WARMUP(1'b0)) dut_r (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov_r), .out_avg(avg_r), .out_primed(op_r), .fill_count(fc_r));

  sma_filter #(.DATA_W(DW), .LOG2_DEPTH(L), .ROUND(0), .SUPPRESS_WARMUP(1'b1)) dut_s (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov_s), .out_avg(avg_s), .out_primed(op_s), .fill_count(fc_s));

  task automatic model_reset();
    win.delete();
    m_avg_t = 0; m_avg_r = 0; m_avg_s = 0;
    m_valid_t = 0; m_valid_s = 0; m_fill = 0; m_primed = 0;
  endtask

  // Apply one cycle of stimulus (from edge+1), advance to the next edge+1 and
  // update the model to what the outputs should now show.
  task automatic tick(input logic v, input logic [DW-1:0] d, input logic c);
    int sum;
    in_valid = v; in_data = d; clear = c;
    @(posedge clk);
    #1;
    if (c) begin
      model_reset();
    end else if (v) begin
      win.push_back(int'(d));
      if (win.size() > N) void'(win.pop_front());
      sum = 0;
      foreach (win[i]) sum += win[i];
      m_avg_t   = sum / N;
      m_avg_r   = (sum + N / 2) / N;
      m_fill    = win.size();
      m_primed  = (m_fill == N) ? 1 : 0;
      m_valid_t = 1;
      m_valid_s = m_primed;
      if (m_primed != 0) m_avg_s = m_avg_t;
    end else begin
      m_valid_t = 0;
      m_valid_s = 0;
    end
    in_valid = 1'b0; clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    n_checks++;
    if ({ov_t, avg_t, op_t, fc_t} !== '0) begin
      n_fail++; $display("FAIL reset_t: got v=%b avg=%0d p=%b fc=%0d, want all 0", ov_t, avg_t, op_t, fc_t);
    end
    n_checks++;
    if ({ov_r, avg_r, op_r, fc_r} !== '0) begin
      n_fail++; $display("FAIL reset_r: got v=%b avg=%0d p=%b fc=%0d, want all 0", ov_r, avg_r, op_r, fc_r);
    end
    n_checks++;
    if ({ov_s, avg_s, op_s, fc_s} !== '0) begin
      n_fail++; $display("FAIL reset_s: got v=%b avg=%0d p=%b fc=%0d, want all 0", ov_s, avg_s, op_s, fc_s);
    end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_ramp();
    int exp_t[8] = '{12, 25, 37, 50, 62, 75, 87, 100};
    int exp_r[8] = '{13, 25, 38, 50, 63, 75, 88, 100};
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, 8'd100, 1'b0);
      n_checks++;
      if (int'(avg_t) != exp_t[i] || ov_t !== 1'b1) begin
        n_fail++; $display("FAIL ramp_trunc[%0d]: got avg=%0d v=%b, want avg=%0d v=1", i, avg_t, ov_t, exp_t[i]);
      end
      n_checks++;
      if (int'(avg_r) != exp_r[i] || ov_r !== 1'b1) begin
        n_fail++; $display("FAIL ramp_round[%0d]: got avg=%0d v=%b, want avg=%0d v=1", i, avg_r, ov_r, exp_r[i]);
      end
      n_checks++;
      if (int'(fc_t) != i + 1 || op_t !== (i == 7)) begin
        n_fail++; $display("FAIL ramp_fill[%0d]: got fc=%0d p=%b, want fc=%0d p=%b", i, fc_t, op_t, i + 1, (i == 7));
      end
    end
  endtask

  task automatic test_saturation();
    int exp_d[8] = '{223, 191, 159, 127, 95, 63, 31, 0};
    tick(1'b0, 8'd0, 1'b1);
    for (int i = 0; i < 9; i++) begin
      tick(1'b1, 8'd255, 1'b0);
      n_checks++;
      if (int'(avg_t) != m_avg_t || (i >= 7 && avg_t !== 8'd255)) begin
        n_fail++; $display("FAIL sat_up[%0d]: got avg=%0d, want %0d", i, avg_t, m_avg_t);
      end
    end
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, 8'd0, 1'b0);
      n_checks++;
      if (int'(avg_t) != exp_d[i] || fc_t !== 4'd8) begin
        n_fail++; $display("FAIL sat_wrap[%0d]: got avg=%0d fc=%0d, want avg=%0d fc=8", i, avg_t, fc_t, exp_d[i]);
      end
    end
  endtask

  task automatic test_gapped();
    int exp_t[8] = '{12, 25, 37, 50, 62, 75, 87, 100};
    tick(1'b0, 8'd0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) tick(1'b1, 8'd100, 1'b0);
      else            tick(1'b0, 8'($urandom_range(0, 255)), 1'b0);
      n_checks++;
      if (int'(avg_t) != exp_t[i / 2] || ov_t !== (i % 2 == 0)) begin
        n_fail++; $display("FAIL gapped[%0d]: got avg=%0d v=%b, want avg=%0d v=%b", i, avg_t, ov_t, exp_t[i / 2], (i % 2 == 0));
      end
    end
  endtask

  task automatic test_clear_collision();
    tick(1'b0, 8'd0, 1'b1);
    for (int i = 0; i < 8; i++) tick(1'b1, 8'd100, 1'b0);
    tick(1'b1, 8'd200, 1'b1);
    n_checks++;
    if (avg_t !== 8'd0 || fc_t !== 4'd0 || op_t !== 1'b0 || ov_t !== 1'b0) begin
      n_fail++; $display("FAIL clear_hit: got avg=%0d fc=%0d p=%b v=%b, want 0 0 0 0", avg_t, fc_t, op_t, ov_t);
    end
    tick(1'b1, 8'd80, 1'b0);
    n_checks++;
    if (avg_t !== 8'd10 || fc_t !== 4'd1 || ov_t !== 1'b1) begin
      n_fail++; $display("FAIL clear_after: got avg=%0d fc=%0d v=%b, want 10 1 1", avg_t, fc_t, ov_t);
    end
  endtask

  task automatic test_suppress_and_async_reset();
    reset = 1'b1; #1; reset = 1'b0;
    model_reset();
    for (int i = 0; i < 7; i++) begin
      tick(1'b1, 8'd100, 1'b0);
      n_checks++;
      if (ov_s !== 1'b0) begin
        n_fail++; $display("FAIL warmup[%0d]: got v=%b, want 0", i, ov_s);
      end
    end
    tick(1'b1, 8'd100, 1'b0);
    n_checks++;
    if (ov_s !== 1'b1 || avg_s !== 8'd100 || op_s !== 1'b1) begin
      n_fail++; $display("FAIL warmup_full: got v=%b avg=%0d p=%b, want 1 100 1", ov_s, avg_s, op_s);
    end
    #1; reset = 1'b1; #1;
    n_checks++;
    if ({ov_t, avg_t, op_t, fc_t, ov_s, avg_s, op_s, fc_s} !== '0) begin
      n_fail++; $display("FAIL async_reset: got t avg=%0d fc=%0d s avg=%0d fc=%0d, want 0", avg_t, fc_t, avg_s, fc_s);
    end
    #1; reset = 1'b0;
    model_reset();
    tick(1'b1, 8'd40, 1'b0);
    n_checks++;
    if (avg_t !== 8'd5 || fc_t !== 4'd1 || ov_t !== 1'b1) begin
      n_fail++; $display("FAIL post_reset: got avg=%0d fc=%0d v=%b, want 5 1 1", avg_t, fc_t, ov_t);
    end
  endtask

  task automatic test_random();
    logic v, c;
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 24) == 0);
      tick(v, 8'($urandom_range(0, 255)), c);
      n_checks++;
      if (int'(avg_t) != m_avg_t || int'(ov_t) != m_valid_t) begin
        n_fail++; $display("FAIL rand_t[%0d]: got avg=%0d v=%b, want avg=%0d v=%0d", i, avg_t, ov_t, m_avg_t, m_valid_t);
      end
      n_checks++;
      if (int'(avg_r) != m_avg_r || int'(ov_r) != m_valid_t) begin
        n_fail++; $display("FAIL rand_r[%0d]: got avg=%0d v=%b, want avg=%0d v=%0d", i, avg_r, ov_r, m_avg_r, m_valid_t);
      end
      n_checks++;
      if (int'(avg_s) != m_avg_s || int'(ov_s) != m_valid_s) begin
        n_fail++; $display("FAIL rand_s[%0d]: got avg=%0d v=%b, want avg=%0d v=%0d", i, avg_s, ov_s, m_avg_s, m_valid_s);
      end
      n_checks++;
      if (int'(fc_t) != m_fill || int'(op_t) != m_primed || int'(fc_s) != m_fill || int'(op_s) != m_primed) begin
        n_fail++; $display("FAIL rand_fill[%0d]: got fc=%0d/%0d p=%b/%b, want fc=%0d p=%0d", i, fc_t, fc_s, op_t, op_s, m_fill, m_primed);
      end
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_ramp();
    test_saturation();
    test_gapped();
    test_clear_collision();
    test_suppress_and_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sma_filter.md
# sma_filter

Parametrised simple-moving-average filter over the last 2^LOG2_DEPTH accepted samples of a price stream. It replaces the fixed 8-deep, 8-bit averager and adds the following:
- sample-valid qualification, so the window advances only on real ticks;
- a circular-buffer window;
- selectable rounding;
- a synchronous clear;
- window-fill status, with optional warm-up suppression.

It sits between the tick-input stage and the trading-signal logic, one instance per averaging window.

## Interface
- DATA_W, 8: sample and average width, unsigned.
- LOG2_DEPTH, 3: window depth N = 2^LOG2_DEPTH. Legal range is 1..8.
- ROUND, 0: 0 truncates the division; 1 rounds half-up.
- SUPPRESS_WARMUP, 0: 0 emits averages from the first sample, with empty slots counting as zero; 1 holds out_valid low until the window is full.
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- clear  in  1  synchronous flush of the window, sum, pointer and fill count.
- in_valid  in  1  in_data is a new sample this cycle.
- in_data  in  DATA_W  sample value.
- out_valid  out  1  out_avg updated this cycle (one-cycle pulse per accepted sample).
- out_avg  out  DATA_W  current moving average; holds its value between updates.
- out_primed  out  1  window holds N real samples since the last reset or clear.
- fill_count  out  LOG2_DEPTH+1  accepted samples in the window, saturating at N.

## Operation
- State:
  - buf[0..N-1], DATA_W flops each;
  - wr_ptr, LOG2_DEPTH bits;
  - sum, DATA_W+LOG2_DEPTH bits;
  - fill_count.
- Accept rule: a sample is accepted when in_valid=1 and clear=0.
- On accept:
  - sum_next = sum − buf[wr_ptr] + in_data;
  - buf[wr_ptr] ← in_data;
  - wr_ptr increments, wrapping N−1→0;
  - fill_count ← min(fill_count+1, N).
- The average is always computed from sum_next, never from the stale sum:
  - ROUND=0: out_avg ← sum_next >> LOG2_DEPTH;
  - ROUND=1: out_avg ← (sum_next + 2^(LOG2_DEPTH−1)) >> LOG2_DEPTH.
- Width rules:
  - sum cannot overflow, since its maximum is (2^DATA_W−1)·N.
  - The rounding add is evaluated at DATA_W+LOG2_DEPTH bits and cannot overflow; the maximum result is 2^DATA_W−1.
- out_primed = (fill_count == N), registered alongside fill_count.
- out_valid:
  - set the cycle after an accept;
  - if SUPPRESS_WARMUP=1, set only for accepts that bring or keep fill_count at N.
- clear:
  - all buf entries ← 0, sum ← 0, wr_ptr ← 0, fill_count ← 0;
  - out_valid ← 0 and out_primed ← 0;
  - out_avg ← 0.
- clear with in_valid in the same cycle: clear wins and the sample is dropped.
- in_valid=0 and clear=0: all state holds and out_valid ← 0.

## Timing
- Reset values: out_valid=0, out_avg=0, out_primed=0, fill_count=0. Also buf, sum and wr_ptr are all zero.
- Latency: exactly 1 cycle from an accepted sample to out_valid/out_avg. Full throughput: one sample per cycle, back-to-back.
- No backpressure. The block is always ready, and in_valid is never stalled.
- Wrap-around: the (N+1)th accept overwrites the 1st sample. Steady state is sum = Σ(last N accepted samples).
- Gaps in in_valid do not age the window; only accepts advance it.
- Reset mid-stream: every output goes to its reset value asynchronously. The first accept after deassertion behaves as the first sample.
- clear takes effect at the next edge. The cycle after it, out_valid=0 and fill_count=0.

## Structure
- Package sma_pkg:
  - function sum_w(DATA_W, LOG2_DEPTH) = DATA_W+LOG2_DEPTH;
  - localparam/enum for rounding mode (RND_TRUNC=0, RND_HALF_UP=1);
  - function depth(LOG2_DEPTH) = 1 << LOG2_DEPTH.
- One sub-module, sma_window_buf. It holds the circular buffer, wr_ptr and the read of the evicted entry: write-enable, clear, write data, and the oldest-value output taken combinationally at wr_ptr.
- Sum, divide/round, fill and valid logic live in sma_filter.

## Test plan
Defaults (DATA_W=8, LOG2_DEPTH=3) unless stated.
- Ramp-up, ROUND=0: reset, then 8 back-to-back samples of 100 → out_avg 12,25,37,50,62,75,87,100. out_valid is high on each cycle after an accept; out_primed rises with the 8th output; fill_count runs 1..8.
- ROUND=1, same stimulus → out_avg 13,25,38,50,63,75,88,100.
- Saturation and wrap, ROUND=0:
  - 9 samples of 255 → out_avg 255 from the 8th on, no overflow;
  - then 8 samples of 0 → 223,191,159,127,95,63,31,0;
  - fill_count stays 8 throughout.
- Gapped input: the ramp-up stimulus with in_valid low on alternate cycles → identical out_avg sequence. out_valid pulses only after accepts, and out_avg holds during gaps.
- Clear collision:
  - after 8×100, assert clear with in_valid=1, in_data=200 → the sample is dropped;
  - next cycle: out_avg=0, fill_count=0, out_primed=0;
  - then in_data=80 → out_avg=10, fill_count=1.
- SUPPRESS_WARMUP=1, plus async reset: 7 samples of 100 → out_valid never high, and the 8th gives out_valid=1 with out_avg=100. Asserting reset mid-cycle zeroes all outputs before the next edge.
